rrat_nway: RTL and testbench

Parametrised N-way retirement register alias table for the out-of-order core. Sits behind the ROB and accepts up to COMMIT_WIDTH in-order retirements per cycle. Keeps the committed architectural-to-physical map and the retirement-view PRF free list, and returns each displaced PRF for reclamation. Adds same-bundle ARF collision handling, a free count, a sticky commit-error flag and optional zero-register filtering.

---
 rtl/rrat_nway.sv | 130 +++++++++++++
 tb/tb_rrat_nway.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rrat_nway.sv
// rrat_nway: N-way retirement register alias table.
//
// Holds the committed architectural-to-physical register map and the
// retirement-view PRF free list. Up to COMMIT_WIDTH in-order retirements are
// applied per cycle, lane 0 oldest, each lane seeing the effects of the lower
// lanes in the same bundle. Every valid lane returns the PRF it displaced.
//
// Optional feature (macro RRAT_ZERO_REG_EN): ARF index ARF_SIZE-1 is a
// hardwired zero register. Commits to it leave the map, free list and error
// flag untouched, and the committed PRF is handed straight back on the lane's
// free port.
//
// Ports:
//   clock, reset               single clock, synchronous active-high reset
//   ROB_commit_valid_in        per-lane commit valid
//   ROB_ARF_num_in             per-lane destination ARF, lane i at [i*ARF_W +: ARF_W]
//   ROB_PRF_num_in             per-lane committed PRF,   lane i at [i*PRF_W +: PRF_W]
//   RRAT_PRF_FL_out            free list, bit p = 1 when PRF p is not committed
//   RRAT_copy_out              flattened map, entry a at [a*PRF_W +: PRF_W]
//   RRAT_free_PRF_num_out      per-lane displaced PRF (holds when valid is 0)
//   RRAT_free_valid_out        per-lane one-cycle valid for the displaced PRF
//   RRAT_free_count_out        popcount of RRAT_PRF_FL_out
//   RRAT_commit_err_out        sticky: a lane committed a PRF already committed
module rrat_nway #(
    parameter int ARF_SIZE     = 32,
    parameter int PRF_SIZE     = 64,
    parameter int COMMIT_WIDTH = 2,
    localparam int ARF_W       = $clog2(ARF_SIZE),
    localparam int PRF_W       = $clog2(PRF_SIZE),
    localparam int CNT_W       = $clog2(PRF_SIZE + 1)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [COMMIT_WIDTH-1:0]         ROB_commit_valid_in,
    input  logic [COMMIT_WIDTH*ARF_W-1:0]   ROB_ARF_num_in,
    input  logic [COMMIT_WIDTH*PRF_W-1:0]   ROB_PRF_num_in,
    output logic [PRF_SIZE-1:0]             RRAT_PRF_FL_out,
    output logic [ARF_SIZE*PRF_W-1:0]       RRAT_copy_out,
    output logic [COMMIT_WIDTH*PRF_W-1:0]   RRAT_free_PRF_num_out,
    output logic [COMMIT_WIDTH-1:0]         RRAT_free_valid_out,
    output logic [CNT_W-1:0]                RRAT_free_count_out,
    output logic                            RRAT_commit_err_out
);

    logic [ARF_SIZE-1:0][PRF_W-1:0]     map_q, map_n;
    logic [PRF_SIZE-1:0]                fl_q, fl_n;
    logic [COMMIT_WIDTH-1:0][PRF_W-1:0] fnum_q, fnum_n;
    logic [COMMIT_WIDTH-1:0]            fval_q, fval_n;
    logic [CNT_W-1:0]                   cnt_q, cnt_n;
    logic                               err_q, err_n;

    logic [ARF_W-1:0]                   lane_arf;
    logic [PRF_W-1:0]                   lane_prf;
    logic [PRF_W-1:0]                   lane_old;
    logic                               zero_hit;

    // Lanes are folded in order onto the running next-state copy, so a later
    // lane targeting the same ARF displaces (and frees) the earlier lane's PRF.
    always_comb begin
        map_n    = map_q;
        fl_n     = fl_q;
        fnum_n   = fnum_q;
        fval_n   = '0;
        err_n    = err_q;
        cnt_n    = '0;
        lane_arf = '0;
        lane_prf = '0;
        lane_old = '0;
        zero_hit = 1'b0;

        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            lane_arf = ROB_ARF_num_in[i*ARF_W +: ARF_W];
            lane_prf = ROB_PRF_num_in[i*PRF_W +: PRF_W];
            lane_old = map_n[lane_arf];
`ifdef RRAT_ZERO_REG_EN
            zero_hit = (lane_arf == ARF_W'(ARF_SIZE - 1));
`else
            zero_hit = 1'b0;
`endif
            if (ROB_commit_valid_in[i]) begin
                fval_n[i] = 1'b1;
                if (zero_hit) begin
                    fnum_n[i] = lane_prf;
                end else begin
                    if (!fl_n[lane_prf]) begin
                        err_n = 1'b1;
                    end
                    fnum_n[i]       = lane_old;
                    map_n[lane_arf] = lane_prf;
                    fl_n[lane_prf]  = 1'b0;
                    fl_n[lane_old]  = 1'b1;
                end
            end
        end

        for (int k = 0; k < PRF_SIZE; k++) begin
            cnt_n = cnt_n + CNT_W'(fl_n[k]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int a = 0; a < ARF_SIZE; a++) begin
                map_q[a] <= PRF_W'(a);
            end
            for (int p = 0; p < PRF_SIZE; p++) begin
                fl_q[p] <= (p >= ARF_SIZE);
            end
            fnum_q <= '0;
            fval_q <= '0;
            cnt_q  <= CNT_W'(PRF_SIZE - ARF_SIZE);
            err_q  <= 1'b0;
        end else begin
            map_q  <= map_n;
            fl_q   <= fl_n;
            fnum_q <= fnum_n;
            fval_q <= fval_n;
            cnt_q  <= cnt_n;
            err_q  <= err_n;
        end
    end

    assign RRAT_PRF_FL_out       = fl_q;
    assign RRAT_copy_out         = map_q;
    assign RRAT_free_PRF_num_out = fnum_q;
    assign RRAT_free_valid_out   = fval_q;
    assign RRAT_free_count_out   = cnt_q;
    assign RRAT_commit_err_out   = err_q;

endmodule

// File: tb/tb_rrat_nway.sv
// Self-checking bench for rrat_nway at default parameters. Each drive pushes
// the expected post-edge state (from a behavioural model of the retirement
// rules) onto a scoreboard queue; scenario tasks pop it after the edge and
// compare, alongside hand-derived constants for the directed cases.
module tb_rrat_nway;

    localparam int ARF_SIZE = 32;
    localparam int PRF_SIZE = 64;
    localparam int CW       = 2;
    localparam int ARF_W    = 5;
    localparam int PRF_W    = 6;
    localparam int CNT_W    = 7;

    logic                      clock;
    logic                      reset;
    logic [CW-1:0]             ROB_commit_valid_in;
    logic [CW*ARF_W-1:0]       ROB_ARF_num_in;
    logic [CW*PRF_W-1:0]       ROB_PRF_num_in;
    logic [PRF_SIZE-1:0]       RRAT_PRF_FL_out;
    logic [ARF_SIZE*PRF_W-1:0] RRAT_copy_out;
    logic [CW*PRF_W-1:0]       RRAT_free_PRF_num_out;
    logic [CW-1:0]             RRAT_free_valid_out;
    logic [CNT_W-1:0]          RRAT_free_count_out;
    logic                      RRAT_commit_err_out;

    rrat_nway #(.ARF_SIZE(ARF_SIZE), .PRF_SIZE(PRF_SIZE), .COMMIT_WIDTH(CW)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .ROB_commit_valid_in   (ROB_commit_valid_in),
        .ROB_ARF_num_in        (ROB_ARF_num_in),
        .ROB_PRF_num_in        (ROB_PRF_num_in),
        .RRAT_PRF_FL_out       (RRAT_PRF_FL_out),
        .RRAT_copy_out         (RRAT_copy_out),
        .RRAT_free_PRF_num_out (RRAT_free_PRF_num_out),
        .RRAT_free_valid_out   (RRAT_free_valid_out),
        .RRAT_free_count_out   (RRAT_free_count_out),
        .RRAT_commit_err_out   (RRAT_commit_err_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [PRF_SIZE-1:0]       fl;
        logic [ARF_SIZE*PRF_W-1:0] copy;
        logic [CW*PRF_W-1:0]       fnum;
        logic [CW-1:0]             fval;
        logic [CNT_W-1:0]          cnt;
        logic                      err;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int n_tests = 0;
    int n_fail  = 0;

    int              m_map [ARF_SIZE];
    logic [63:0]     m_fl;
    logic            m_err;
    logic [PRF_W-1:0] m_fnum [CW];
    logic [CW-1:0]   m_fval;

    function automatic logic [PRF_W-1:0] entry(input int a);
        logic [ARF_SIZE*PRF_W-1:0] c;
        c = RRAT_copy_out;
        return c[a*PRF_W +: PRF_W];
    endfunction

    task automatic model_reset();
        for (int a = 0; a < ARF_SIZE; a++) m_map[a] = a;
        for (int p = 0; p < PRF_SIZE; p++) m_fl[p] = (p >= ARF_SIZE);
        m_err = 1'b0;
        for (int l = 0; l < CW; l++) m_fnum[l] = '0;
        m_fval = '0;
    endtask

    task automatic model_lane(input int lane, input int a, input int p);
        int old;
        m_fval[lane] = 1'b1;
`ifdef RRAT_ZERO_REG_EN
        if (a == ARF_SIZE - 1) begin
            m_fnum[lane] = PRF_W'(p);
            return;
        end
`endif
        old = m_map[a];
        if (!m_fl[p]) m_err = 1'b1;
        m_fnum[lane] = PRF_W'(old);
        m_map[a] = p;
        m_fl[p] = 1'b0;
        m_fl[old] = 1'b1;
    endtask

    // Drive one cycle of stimulus, push the model's expected state, step the edge.
    task automatic drive(input logic rst, input logic [1:0] v,
                         input int a0, input int p0, input int a1, input int p1);
        exp_t x;
        reset               = rst;
        ROB_commit_valid_in = v;
        ROB_ARF_num_in      = {a1[ARF_W-1:0], a0[ARF_W-1:0]};
        ROB_PRF_num_in      = {p1[PRF_W-1:0], p0[PRF_W-1:0]};
        if (rst) begin
            model_reset();
        end else begin
            m_fval = '0;
            if (v[0]) model_lane(0, a0, p0);
            if (v[1]) model_lane(1, a1, p1);
        end
        x.fl = m_fl;
        for (int a = 0; a < ARF_SIZE; a++) x.copy[a*PRF_W +: PRF_W] = PRF_W'(m_map[a]);
        x.fnum = {m_fnum[1], m_fnum[0]};
        x.fval = m_fval;
        x.cnt  = CNT_W'($countones(m_fl));
        x.err  = m_err;
        sb.push_back(x);
        @(posedge clock);
        #1;
        reset               = 1'b0;
        ROB_commit_valid_in = '0;
    endtask

    task automatic pop(input string nm);
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard empty got 0 entries need 1", nm);
            e = '{default: '0};
        end else begin
            e = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 2'b00, 0, 0, 0, 0);
        pop("reset_c1");
        drive(1'b1, 2'b00, 0, 0, 0, 0);
        pop("reset_c2");
        n_tests++;
        if (RRAT_PRF_FL_out !== 64'hFFFF_FFFF_0000_0000) begin
            n_fail++; $display("FAIL reset_fl got %h need %h", RRAT_PRF_FL_out, 64'hFFFF_FFFF_0000_0000);
        end
        n_tests++;
        if (RRAT_free_count_out !== 7'd32) begin
            n_fail++; $display("FAIL reset_count got %0d need 32", RRAT_free_count_out);
        end
        n_tests++;
        if (RRAT_free_valid_out !== 2'b00 || RRAT_free_PRF_num_out !== '0) begin
            n_fail++; $display("FAIL reset_free got v=%b n=%h need v=00 n=0", RRAT_free_valid_out, RRAT_free_PRF_num_out);
        end
        n_tests++;
        if (RRAT_commit_err_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_err got %b need 0", RRAT_commit_err_out);
        end
        for (int a = 0; a < ARF_SIZE; a++) begin
            n_tests++;
            if (entry(a) !== PRF_W'(a)) begin
                n_fail++; $display("FAIL reset_entry%0d got %0d need %0d", a, entry(a), a);
            end
        end
    endtask

    task automatic test_single_lane();
        drive(1'b0, 2'b01, 0, 63, 0, 0);
        pop("single");
        n_tests++;
        if (RRAT_free_PRF_num_out[PRF_W-1:0] !== 6'd0 || RRAT_free_valid_out !== 2'b01) begin
            n_fail++; $display("FAIL single_free got n0=%0d v=%b need n0=0 v=01",
                               RRAT_free_PRF_num_out[PRF_W-1:0], RRAT_free_valid_out);
        end
        n_tests++;
        if (entry(0) !== 6'd63) begin
            n_fail++; $display("FAIL single_entry0 got %0d need 63", entry(0));
        end
        n_tests++;
        if (RRAT_PRF_FL_out[63] !== 1'b0 || RRAT_PRF_FL_out[0] !== 1'b1) begin
            n_fail++; $display("FAIL single_fl got fl63=%b fl0=%b need 0 1", RRAT_PRF_FL_out[63], RRAT_PRF_FL_out[0]);
        end
        n_tests++;
        if (RRAT_free_count_out !== 7'd32 || RRAT_PRF_FL_out !== e.fl) begin
            n_fail++; $display("FAIL single_state got cnt=%0d fl=%h need cnt=32 fl=%h",
                               RRAT_free_count_out, RRAT_PRF_FL_out, e.fl);
        end
        drive(1'b0, 2'b00, 0, 0, 0, 0);
        pop("single_idle");
        n_tests++;
        if (RRAT_free_valid_out !== 2'b00 || RRAT_free_PRF_num_out !== e.fnum) begin
            n_fail++; $display("FAIL single_idle got v=%b n=%h need v=00 n=%h",
                               RRAT_free_valid_out, RRAT_free_PRF_num_out, e.fnum);
        end
    endtask

    task automatic test_error();
        drive(1'b0, 2'b01, 3, 63, 0, 0);
        pop("error");
        n_tests++;
        if (RRAT_commit_err_out !== 1'b1) begin
            n_fail++; $display("FAIL error_set got %b need 1", RRAT_commit_err_out);
        end
        n_tests++;
        if (entry(3) !== 6'd63 || RRAT_free_PRF_num_out[PRF_W-1:0] !== 6'd3) begin
            n_fail++; $display("FAIL error_apply got entry3=%0d n0=%0d need 63 3",
                               entry(3), RRAT_free_PRF_num_out[PRF_W-1:0]);
        end
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 2'b00, 0, 0, 0, 0);
            pop("error_idle");
            n_tests++;
            if (RRAT_commit_err_out !== e.err) begin
                n_fail++; $display("FAIL error_sticky got %b need %b", RRAT_commit_err_out, e.err);
            end
        end
        drive(1'b1, 2'b00, 0, 0, 0, 0);
        pop("error_reset");
        n_tests++;
        if (RRAT_commit_err_out !== 1'b0) begin
            n_fail++; $display("FAIL error_clear got %b need 0", RRAT_commit_err_out);
        end
    endtask

    task automatic test_collision();
        drive(1'b0, 2'b11, 5, 40, 5, 41);
        pop("collision");
        n_tests++;
        if (RRAT_free_PRF_num_out !== {6'd40, 6'd5} || RRAT_free_valid_out !== 2'b11) begin
            n_fail++; $display("FAIL collision_free got n=%h v=%b need n=%h v=11",
                               RRAT_free_PRF_num_out, RRAT_free_valid_out, {6'd40, 6'd5});
        end
        n_tests++;
        if (entry(5) !== 6'd41) begin
            n_fail++; $display("FAIL collision_entry5 got %0d need 41", entry(5));
        end
        n_tests++;
        if (RRAT_PRF_FL_out[5] !== 1'b1 || RRAT_PRF_FL_out[40] !== 1'b1 || RRAT_PRF_FL_out[41] !== 1'b0) begin
            n_fail++; $display("FAIL collision_fl got fl5=%b fl40=%b fl41=%b need 1 1 0",
                               RRAT_PRF_FL_out[5], RRAT_PRF_FL_out[40], RRAT_PRF_FL_out[41]);
        end
        n_tests++;
        if (RRAT_free_count_out !== 7'd32 || RRAT_commit_err_out !== 1'b0) begin
            n_fail++; $display("FAIL collision_cnt got cnt=%0d err=%b need 32 0", RRAT_free_count_out, RRAT_commit_err_out);
        end
    endtask

    task automatic test_zero_reg();
        drive(1'b1, 2'b00, 0, 0, 0, 0);
        pop("zero_reset");
        drive(1'b0, 2'b01, 31, 50, 0, 0);
        pop("zero");
`ifdef RRAT_ZERO_REG_EN
        n_tests++;
        if (RRAT_free_PRF_num_out[PRF_W-1:0] !== 6'd50 || RRAT_free_valid_out[0] !== 1'b1) begin
            n_fail++; $display("FAIL zero_free got n0=%0d v0=%b need 50 1",
                               RRAT_free_PRF_num_out[PRF_W-1:0], RRAT_free_valid_out[0]);
        end
        n_tests++;
        if (entry(31) !== 6'd31 || RRAT_PRF_FL_out !== 64'hFFFF_FFFF_0000_0000) begin
            n_fail++; $display("FAIL zero_state got entry31=%0d fl=%h need 31 %h",
                               entry(31), RRAT_PRF_FL_out, 64'hFFFF_FFFF_0000_0000);
        end
`else
        n_tests++;
        if (RRAT_free_PRF_num_out[PRF_W-1:0] !== 6'd31 || RRAT_free_valid_out[0] !== 1'b1) begin
            n_fail++; $display("FAIL zero_free got n0=%0d v0=%b need 31 1",
                               RRAT_free_PRF_num_out[PRF_W-1:0], RRAT_free_valid_out[0]);
        end
        n_tests++;
        if (entry(31) !== 6'd50 || RRAT_PRF_FL_out[50] !== 1'b0 || RRAT_PRF_FL_out[31] !== 1'b1) begin
            n_fail++; $display("FAIL zero_state got entry31=%0d fl50=%b fl31=%b need 50 0 1",
                               entry(31), RRAT_PRF_FL_out[50], RRAT_PRF_FL_out[31]);
        end
`endif
        n_tests++;
        if (RRAT_PRF_FL_out !== e.fl || RRAT_copy_out !== e.copy) begin
            n_fail++; $display("FAIL zero_model got fl=%h need fl=%h", RRAT_PRF_FL_out, e.fl);
        end
    endtask

    function automatic int pick_free(input int avoid);
        int start, idx;
        start = $urandom_range(0, PRF_SIZE - 1);
        for (int k = 0; k < PRF_SIZE; k++) begin
            idx = (start + k) % PRF_SIZE;
            if (m_fl[idx] && idx != avoid) return idx;
        end
        return 0;
    endfunction

    // Random legal retirement stream, with frequent same-ARF bundles.
    task automatic test_back_to_back();
        int a0, a1, p0, p1;
        logic [1:0] v;
        drive(1'b1, 2'b00, 0, 0, 0, 0);
        pop("b2b_reset");
        for (int c = 0; c < 200; c++) begin
            v  = 2'($urandom_range(0, 3));
            a0 = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, ARF_SIZE - 1);
            a1 = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, ARF_SIZE - 1);
            p0 = pick_free(-1);
            p1 = pick_free(p0);
            drive(1'b0, v, a0, p0, a1, p1);
            pop("b2b");
            n_tests++;
            if (RRAT_PRF_FL_out !== e.fl || RRAT_copy_out !== e.copy || RRAT_free_count_out !== e.cnt ||
                RRAT_free_valid_out !== e.fval || RRAT_free_PRF_num_out !== e.fnum ||
                RRAT_commit_err_out !== e.err) begin
                n_fail++;
                $display("FAIL b2b cycle %0d got fl=%h cnt=%0d v=%b n=%h err=%b need fl=%h cnt=%0d v=%b n=%h err=%b",
                         c, RRAT_PRF_FL_out, RRAT_free_count_out, RRAT_free_valid_out, RRAT_free_PRF_num_out,
                         RRAT_commit_err_out, e.fl, e.cnt, e.fval, e.fnum, e.err);
            end
            n_tests++;
            if (RRAT_free_count_out !== 7'd32 || RRAT_commit_err_out !== 1'b0) begin
                n_fail++; $display("FAIL b2b_invariant got cnt=%0d err=%b need 32 0",
                                   RRAT_free_count_out, RRAT_commit_err_out);
            end
        end
    endtask

    task automatic test_reset_collision();
        drive(1'b0, 2'b01, 0, pick_free(-1), 0, 0);
        pop("rstcol_pre");
        drive(1'b1, 2'b01, 0, 63, 0, 0);
        pop("rstcol");
        n_tests++;
        if (entry(0) !== 6'd0 || RRAT_copy_out !== e.copy) begin
            n_fail++; $display("FAIL rstcol_map got entry0=%0d need 0", entry(0));
        end
        n_tests++;
        if (RRAT_PRF_FL_out !== 64'hFFFF_FFFF_0000_0000 || RRAT_free_count_out !== 7'd32) begin
            n_fail++; $display("FAIL rstcol_fl got fl=%h cnt=%0d need %h 32",
                               RRAT_PRF_FL_out, RRAT_free_count_out, 64'hFFFF_FFFF_0000_0000);
        end
        n_tests++;
        if (RRAT_free_valid_out !== 2'b00 || RRAT_free_PRF_num_out !== '0 || RRAT_commit_err_out !== 1'b0) begin
            n_fail++; $display("FAIL rstcol_out got v=%b n=%h err=%b need 00 0 0",
                               RRAT_free_valid_out, RRAT_free_PRF_num_out, RRAT_commit_err_out);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset               = 1'b1;
        ROB_commit_valid_in = '0;
        ROB_ARF_num_in      = '0;
        ROB_PRF_num_in      = '0;
        model_reset();
        #1;
        test_reset();
        test_single_lane();
        test_error();
        test_collision();
        test_zero_reg();
        test_back_to_back();
        test_reset_collision();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
